// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter. Each cycle it either advances
// sequentially, loads a redirect target (branch > jr > jump), holds under
// stall, or, if a redirect arrived during a stall, remembers it in PEND and
// applies it on the first unstalled edge.
//
// Handshake note: stall is a level hold (pc frozen while high); the redirect
// requests are single-cycle pulses with no ready/ack. A request seen in RUN is
// either applied at this edge (stall=0) or latched as pending (stall=1).
// Requests seen in PEND are dropped because they come from squashed work.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [2:0]  pcmux_sel,
    output logic        flush,
    output logic        redirect_pending,
    output logic        misalign
);

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    // One-hot source codes shared by pcmux_sel and pend_src.
    localparam logic [2:0] SRC_JUMP   = 3'b001;
    localparam logic [2:0] SRC_BRANCH = 3'b010;
    localparam logic [2:0] SRC_JR     = 3'b100;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] pend_target;
    logic [2:0]  pend_src;
    logic        pend_load;
    logic [2:0]  win_sel;
    logic [31:0] win_target;

    // Sequential address; wraps modulo 2^32 with no overflow flag.
    assign pc_plus4 = pc + PC_STEP;

    // PEND is visible to the pipeline, but never while reset is asserted.
    assign redirect_pending = (state == PEND) && !reset;

    // Pick the oldest requester: EX-stage branch, then EX-stage jr, then ID jump.
    always_comb begin
        win_sel    = 3'b000;
        win_target = 32'h0000_0000;
        if (branch_req) begin
            win_sel    = SRC_BRANCH;
            win_target = branch_target;
        end else if (jr_req) begin
            win_sel    = SRC_JR;
            win_target = jr_target;
        end else if (jump_req) begin
            win_sel    = SRC_JUMP;
            win_target = jump_target;
        end
    end

    // Next-state, next-pc and the combinational mux/flush/misalign outputs.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        pcmux_sel  = 3'b000;
        flush      = 1'b0;
        misalign   = 1'b0;
        pend_load  = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (win_sel != 3'b000) begin
                        if (stall) begin
                            pend_load  = 1'b1;
                            state_next = PEND;
                        end else begin
                            pc_next   = {win_target[31:2], 2'b00};
                            pcmux_sel = win_sel;
                            flush     = 1'b1;
                            misalign  = |win_target[1:0];
                        end
                    end else if (!stall) begin
                        pc_next = pc_plus4;
                    end
                end
                PEND: begin
                    if (!stall) begin
                        pc_next    = {pend_target[31:2], 2'b00};
                        pcmux_sel  = pend_src;
                        flush      = 1'b1;
                        misalign   = |pend_target[1:0];
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // State, pc and pending-redirect registers; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= RUN;
            pend_target <= 32'h0000_0000;
            pend_src    <= 3'b000;
        end else begin
            pc    <= pc_next;
            state <= state_next;
            if (pend_load) begin
                pend_target <= win_target;
                pend_src    <= win_sel;
            end
        end
    end

endmodule
